// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I(M) instruction encoder.
// Field-level requests are checked for legality, packed into 32-bit words
// and queued in a small circular FIFO feeding the instruction consumer.
// Optional feature macro: ENCODER_RV32M_EN (accept R-format funct7=0000001).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. On the request side oReady depends only on the registered FIFO count,
// so it never reacts to iReady in the same cycle. On the output side oValid and
// oInstr come straight from the FIFO head and are stable until popped.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    output logic            oReady,
    input  logic [2:0]      iFormat,
    input  logic [6:0]      iOpcode,
    input  logic [2:0]      iFunct3,
    input  logic [6:0]      iFunct7,
    input  logic [4:0]      iRd,
    input  logic [4:0]      iRs1,
    input  logic [4:0]      iRs2,
    input  logic [31:0]     iImm,
    output logic            oValid,
    input  logic            iReady,
    output logic [31:0]     oInstr,
    output logic            oIllegal,
    output logic [CNTW-1:0] oIssued,
    output logic [CNTW-1:0] oIllegalCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            illegal_q, illegal_d;
    logic [CNTW-1:0] issued_q, issued_d;
    logic [CNTW-1:0] ill_cnt_q, ill_cnt_d;

    logic        legal;
    logic [31:0] word;
    logic        accept, push, pop, full, empty;

    // Legality checks: opcode/format pairing, funct fields and immediate range.
    always_comb begin
        logic op_ok;
        logic f_ok;
        logic imm_ok;
        op_ok  = 1'b0;
        f_ok   = 1'b1;
        imm_ok = 1'b1;
        case (iFormat)
            FMT_R: begin
                op_ok = (iOpcode == OP_REG);
                case (iFunct7)
                    7'b0000000: f_ok = 1'b1;
                    7'b0100000: f_ok = (iFunct3 == 3'b000) || (iFunct3 == 3'b101);
`ifdef ENCODER_RV32M_EN
                    7'b0000001: f_ok = 1'b1;
`else
                    7'b0000001: f_ok = 1'b0;
`endif
                    default:    f_ok = 1'b0;
                endcase
            end
            FMT_I: begin
                op_ok  = (iOpcode == OP_IMM) || (iOpcode == OP_LOAD) || (iOpcode == OP_JALR);
                imm_ok = (iImm == {{20{iImm[11]}}, iImm[11:0]});
                if (iOpcode == OP_IMM) begin
                    if (iFunct3 == 3'b001)
                        f_ok = (iImm[11:5] == 7'b0000000);
                    else if (iFunct3 == 3'b101)
                        f_ok = (iImm[11:5] == 7'b0000000) || (iImm[11:5] == 7'b0100000);
                end else if (iOpcode == OP_LOAD) begin
                    f_ok = (iFunct3 != 3'b011) && (iFunct3 != 3'b110) && (iFunct3 != 3'b111);
                end else begin
                    f_ok = (iFunct3 == 3'b000);
                end
            end
            FMT_S: begin
                op_ok  = (iOpcode == OP_STORE);
                imm_ok = (iImm == {{20{iImm[11]}}, iImm[11:0]});
                f_ok   = (iFunct3 == 3'b000) || (iFunct3 == 3'b001) || (iFunct3 == 3'b010);
            end
            FMT_B: begin
                op_ok  = (iOpcode == OP_BRANCH);
                imm_ok = (iImm == {{19{iImm[12]}}, iImm[12:0]}) && !iImm[0];
                f_ok   = (iFunct3 != 3'b010) && (iFunct3 != 3'b011);
            end
            FMT_U: begin
                op_ok  = (iOpcode == OP_LUI) || (iOpcode == OP_AUIPC);
                imm_ok = (iImm[11:0] == 12'h000);
            end
            FMT_J: begin
                op_ok  = (iOpcode == OP_JAL);
                imm_ok = (iImm == {{11{iImm[20]}}, iImm[20:0]}) && !iImm[0];
            end
            default: op_ok = 1'b0;
        endcase
        legal = op_ok && f_ok && imm_ok;
    end

    // Pack the request fields into the standard RV32 layout for its format.
    always_comb begin
        case (iFormat)
            FMT_R:   word = {iFunct7, iRs2, iRs1, iFunct3, iRd, iOpcode};
            FMT_I:   word = {iImm[11:0], iRs1, iFunct3, iRd, iOpcode};
            FMT_S:   word = {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], iOpcode};
            FMT_B:   word = {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], iOpcode};
            FMT_U:   word = {iImm[31:12], iRd, iOpcode};
            FMT_J:   word = {iImm[20], iImm[10:1], iImm[11], iImm[19:12], iRd, iOpcode};
            default: word = NOP;
        endcase
    end

    // Handshake decode; full/empty come only from the registered count.
    always_comb begin
        full   = (count_q == CW'(DEPTH));
        empty  = (count_q == '0);
        accept = iValid && !full;
        push   = accept && legal;
        pop    = !empty && iReady;
    end

    // Next state for the FIFO storage, pointers, count and counters.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        illegal_d = accept && !legal;
        issued_d  = issued_q;
        ill_cnt_d = ill_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (issued_q != '1)
                issued_d = issued_q + CNTW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (accept && !legal && (ill_cnt_q != '1))
            ill_cnt_d = ill_cnt_q + CNTW'(1);
    end

    // State registers; reset discards queued words at once.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= NOP;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            issued_q  <= '0;
            ill_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            issued_q  <= issued_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Output drive: FIFO head or NOP when empty.
    always_comb begin
        oReady      = !full;
        oValid      = !empty;
        oInstr      = empty ? NOP : mem_q[rd_ptr_q];
        oIllegal    = illegal_q;
        oIssued     = issued_q;
        oIllegalCnt = ill_cnt_q;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I(M) instruction encoder, the producer side of the control decoder. It accepts field-level instruction requests (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake. It checks that each request is legal, packs it into a 32-bit instruction word, and queues the word in a small FIFO. The FIFO output drives the instruction port of the CPU or a self-test stimulus path; the datapath consumes the words with its own valid/ready handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- CNTW, 16: width of the issued and illegal counters.
- iCLK  in  1  system clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iValid  in  1  request valid.
- oReady  out  1  encoder can accept a request.
- iFormat  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- iOpcode  in  7  opcode field.
- iFunct3  in  3  funct3 field (R/I/S/B).
- iFunct7  in  7  funct7 field (R only).
- iRd, iRs1, iRs2  in  5 each  register indices.
- iImm  in  32  signed immediate, as the byte offset or value (U: already shifted, low 12 bits zero).
- oValid  out  1  FIFO head valid.
- iReady  in  1  consumer takes head.
- oInstr  out  32  FIFO head; 32'h00000013 (NOP) when empty.
- oIllegal  out  1  one-cycle pulse, the cycle after an illegal request is accepted.
- oIssued  out  CNTW  count of legal words pushed, saturating.
- oIllegalCnt  out  CNTW  count of illegal requests, saturating.

## Operation
- A request is accepted when iValid && oReady, with oReady = !full. There is no pass-through of pop and push in the same cycle when full: oReady depends only on the registered count.
- Every accepted request is consumed. A legal request is pushed; an illegal request is dropped, raises oIllegal, and increments oIllegalCnt.

Legality (all checks must pass):
- Opcode/format pairing:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- R funct7:
  - 0000000 is legal with any funct3.
  - 0100000 is legal only with funct3 000 or 101.
  - 0000001 is legal only per Configuration.
- Immediate range:
  - I and S: iImm equals its sign-extended low 12 bits.
  - B: iImm equals its sign-extended low 13 bits and iImm[0]=0.
  - J: iImm equals its sign-extended low 21 bits and iImm[0]=0.
  - U: iImm[11:0]=0.
- OP-IMM shifts:
  - funct3=001 requires iImm[11:5]=0.
  - funct3=101 requires iImm[11:5] to be 0000000 or 0100000.
- Load funct3 must be in {000, 001, 010, 100, 101}. Store funct3 must be in {000, 001, 010}. Branch funct3 must not be 010 or 011. JALR funct3 must be 000.

Packing uses the standard RV32 layouts:
- R: funct7|rs2|rs1|f3|rd|op.
- I: imm[11:0]|rs1|f3|rd|op.
- S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
- B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
- U: imm[31:12]|rd|op.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.

FIFO and counters:
- The FIFO is a circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Push and pop in the same cycle leave the count unchanged.
- The counters saturate at all-ones and never wrap.

## Timing
- The encode and legality path is combinational from the inputs. The result is registered into the FIFO on the accepting edge.
- Latency: a word accepted at edge N is visible on oInstr with oValid=1 after edge N when the FIFO was empty.
- oIllegal is high for exactly the cycle after the accepting edge.
- A pop occurs on oValid && iReady; iReady while empty has no effect.
- The FIFO is full at count=DEPTH; oReady falls after the edge that fills it and rises after the first pop.
- Reset values: oReady=1, oValid=0, oInstr=32'h00000013, oIllegal=0, both counters 0, pointers 0.
- Reset asserted mid-operation discards queued words immediately (asynchronously). A request presented during reset is not accepted.

## Configuration
- ENCODER_RV32M_EN defined: funct7=0000001 with format R is legal for any funct3 (MUL..REMU).
- ENCODER_RV32M_EN not defined: such requests are illegal, pulse oIllegal, and increment oIllegalCnt.

## Test plan
- R, op 0110011, f3 000, f7 0, rd 3, rs1 1, rs2 2, iReady=1 -> oInstr 0x002081B3 one cycle later; oIssued=1.
- I, op 0010011, rd 1, rs1 0, imm 5 -> 0x00500093. Then S, op 0100011, f3 010, rs1 1, rs2 2, imm 8 -> 0x0020A423.
- B, op 1100011, f3 000, rs1 1, rs2 2, imm -4 -> 0xFE208EE3. Same request with imm -3 -> dropped, oIllegal pulse, oIllegalCnt=1.
- R, f7 0000001, rs1 6, rs2 7, rd 5 -> with the macro defined, 0x027302B3; without it, oIllegal pulse and no push.
- DEPTH=4, iReady=0, five legal requests back-to-back -> oReady=0 after the 4th; the 5th is held. Raising iReady for one cycle -> the 5th is accepted the next cycle and order is preserved.
- Assert iRST with 3 words queued -> oValid=0, oInstr=0x00000013, counters 0 immediately.
